// File: rtl/filter_reduce_accum_unit_if.sv
// Stream bus for the filter/reduce/accumulate unit: input beat channel and
// output beat channel, each a valid/ready handshake carrying lanes + tags.
interface filter_reduce_accum_unit_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4
);
  localparam int CHW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;

  logic                         valid_in;
  logic                         ready_in;
  logic [N-1:0][DATA_WIDTH-1:0] vector_in;
  logic [CHW-1:0]               chainId_in;
  logic [1:0]                   eof_in;
  logic [1:0]                   bof_in;

  logic                         valid_out;
  logic                         ready_out;
  logic [N-1:0][DATA_WIDTH-1:0] vector_out;
  logic [CHW-1:0]               chainId_out;
  logic [1:0]                   eof_out;
  logic [1:0]                   bof_out;

  // unit side: consumes input beats, produces output beats
  modport slave (
    input  valid_in, vector_in, chainId_in, eof_in, bof_in, ready_out,
    output ready_in, valid_out, vector_out, chainId_out, eof_out, bof_out
  );

  // environment side: produces input beats, consumes output beats
  modport master (
    output valid_in, vector_in, chainId_in, eof_in, bof_in, ready_out,
    input  ready_in, valid_out, vector_out, chainId_out, eof_out, bof_out
  );
endinterface

// File: rtl/filter_reduce_accum_unit.sv
// Two-stage vector unit: bypass, bin-count (filter-reduce) or per-chain
// saturating accumulate of bin counts. Config arrives as a byte stream.

// One lane's bin membership against the selected edge row.
module filter_reduce_accum_lane #(
  parameter int M           = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0]       i_x,
  input  logic [M-1:0][DATA_WIDTH-1:0] i_lo,
  input  logic [M-1:0][DATA_WIDTH-1:0] i_hi,
  output logic [M-1:0]                o_hit,
  output logic [COUNT_WIDTH-1:0]      o_cnt
);
  // half-open bin test lo < x <= hi, plus number of bins hit
  always_comb begin
    o_hit = '0;
    o_cnt = '0;
    for (int j = 0; j < M; j++) begin
      o_hit[j] = (i_x > i_lo[j]) && (i_x <= i_hi[j]);
      o_cnt    = o_cnt + COUNT_WIDTH'(o_hit[j]);
    end
  end
endmodule

module filter_reduce_accum_unit #(
  parameter int N                  = 8,
  parameter int M                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int EDGE_DEPTH         = 4,
  parameter int COUNT_WIDTH        = 16
) (
  input logic       clk,
  input logic       reset_n,
  input logic       tracing,
  input logic [7:0] configId,
  input logic [7:0] configData,
  filter_reduce_accum_unit_if.slave bus
);
  localparam int CHW       = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int AW        = (EDGE_DEPTH > 1) ? $clog2(EDGE_DEPTH) : 1;
  localparam int MW        = (M > 1) ? $clog2(M) : 1;
  localparam int BPW       = DATA_WIDTH / 8;
  localparam int CFG_EDGE0 = 3 * MAX_CHAINS;
  localparam int CFG_TOTAL = CFG_EDGE0 + EDGE_DEPTH * M * BPW;
  localparam int KW        = $clog2(CFG_TOTAL + 1);

  typedef logic [DATA_WIDTH-1:0]  word_t;
  typedef logic [COUNT_WIDTH-1:0] cnt_t;

  // configuration state
  logic [MAX_CHAINS-1:0][7:0]    r_op, r_axis;
  logic [MAX_CHAINS-1:0][AW-1:0] r_addr;
  word_t [M-1:0]                 r_edge [EDGE_DEPTH];
  logic [KW-1:0]                 r_k;
  word_t                         r_word;
  logic [MAX_CHAINS-1:0][N-1:0][COUNT_WIDTH-1:0] r_acc;

  // stage 1: accepted beat plus the chain config it was accepted under
  logic                r_s1_vld;
  word_t [N-1:0]       r_s1_vec;
  logic [CHW-1:0]      r_s1_chain;
  logic [1:0]          r_s1_eof, r_s1_bof;
  logic [7:0]          r_s1_op, r_s1_axis;
  logic [AW-1:0]       r_s1_addr;

  // output stage
  logic                r_vout;
  word_t [N-1:0]       r_vec_out;
  logic [CHW-1:0]      r_chain_out;
  logic [1:0]          r_eof_out, r_bof_out;

  logic                w_adv, w_is_acc, w_emit;
  word_t [M-1:0]       w_row, w_lo, w_hi;
  logic [N-1:0][M-1:0] w_hit;
  cnt_t  [N-1:0]       w_rowcnt, w_cnt, w_accsum;
  logic [N-1:0][COUNT_WIDTH:0] w_sum;
  word_t [N-1:0]       w_out_vec;

  // whole pipe stalls only when the output holds an unaccepted beat
  assign w_adv           = !r_vout || bus.ready_out;
  assign bus.ready_in    = tracing && w_adv;
  assign bus.valid_out   = r_vout;
  assign bus.vector_out  = r_vec_out;
  assign bus.chainId_out = r_chain_out;
  assign bus.eof_out     = r_eof_out;
  assign bus.bof_out     = r_bof_out;

  // bin bounds: upper edge of the last bin repeats the first bin's width
  assign w_row = r_edge[r_s1_addr];
  for (genvar j = 0; j < M; j++) begin : g_bin
    assign w_lo[j] = w_row[j];
    if (j < M - 1) begin : g_mid
      assign w_hi[j] = w_row[j+1];
    end else if (M > 1) begin : g_last
      assign w_hi[j] = w_row[M-1] + w_row[1] - w_row[0];
    end else begin : g_one
      assign w_hi[j] = w_row[0] + word_t'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    filter_reduce_accum_lane #(.M(M), .DATA_WIDTH(DATA_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_lane (
      .i_x(r_s1_vec[i]), .i_lo(w_lo), .i_hi(w_hi), .o_hit(w_hit[i]), .o_cnt(w_rowcnt[i])
    );
  end

  // axis 2 counts lanes per bin; any other axis counts bins per lane
  always_comb begin
    w_cnt = '0;
    if (r_s1_axis == 8'd2) begin
      for (int i = 0; i < M; i++)
        for (int l = 0; l < N; l++)
          w_cnt[i] = w_cnt[i] + cnt_t'(w_hit[l][i]);
    end else begin
      w_cnt = w_rowcnt;
    end
  end

  // saturating acc + counts for the beat's chain
  always_comb begin
    w_sum    = '0;
    w_accsum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum[i]    = {1'b0, r_acc[r_s1_chain][i]} + {1'b0, w_cnt[i]};
      w_accsum[i] = w_sum[i][COUNT_WIDTH] ? '1 : w_sum[i][COUNT_WIDTH-1:0];
    end
  end

  // result select; unknown ops fall through as bypass
  assign w_is_acc = (r_s1_op == 8'd2);
  assign w_emit   = r_s1_vld && (!w_is_acc || r_s1_eof[0]);
  always_comb begin
    w_out_vec = r_s1_vec;
    if (r_s1_op == 8'd1)
      for (int i = 0; i < N; i++) w_out_vec[i] = word_t'(w_cnt[i]);
    else if (w_is_acc)
      for (int i = 0; i < N; i++) w_out_vec[i] = word_t'(w_accsum[i]);
  end

  // stage 1 capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_vld <= 1'b0; r_s1_vec <= '0; r_s1_chain <= '0; r_s1_eof <= '0;
      r_s1_bof <= '0; r_s1_op <= '0; r_s1_axis <= '0; r_s1_addr <= '0;
    end else if (w_adv) begin
      r_s1_vld   <= bus.valid_in && bus.ready_in;
      r_s1_vec   <= bus.vector_in;
      r_s1_chain <= bus.chainId_in;
      r_s1_eof   <= bus.eof_in;
      r_s1_bof   <= bus.bof_in;
      r_s1_op    <= r_op[bus.chainId_in];
      r_s1_axis  <= r_axis[bus.chainId_in];
      r_s1_addr  <= r_addr[bus.chainId_in];
    end
  end

  // output register; non-eof accumulate beats leave no output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vout <= 1'b0; r_vec_out <= '0; r_chain_out <= '0; r_eof_out <= '0; r_bof_out <= '0;
    end else if (w_adv) begin
      r_vout      <= w_emit;
      r_vec_out   <= w_out_vec;
      r_chain_out <= r_s1_chain;
      r_eof_out   <= r_s1_eof;
      r_bof_out   <= r_s1_bof;
    end
  end

  // config byte decode
  logic          w_cfg_hit, w_cfg_take, w_last;
  int            w_k, w_eb, w_widx;
  logic [CHW-1:0] w_ci;
  logic [AW-1:0]  w_erow;
  logic [MW-1:0]  w_ecol;
  word_t          w_word_nxt;

  assign w_cfg_hit  = (configId == 8'(PERSONAL_CONFIG_ID));
  assign w_cfg_take = w_cfg_hit && !tracing && (r_k < KW'(CFG_TOTAL));
  assign w_k        = int'(r_k);
  assign w_word_nxt = word_t'({r_word, configData});
  always_comb begin
    w_eb   = w_k - CFG_EDGE0;
    w_widx = w_eb / BPW;
    w_last = (w_eb % BPW) == BPW - 1;
    w_ci   = CHW'(w_k % MAX_CHAINS);
    w_erow = AW'(w_widx / M);
    w_ecol = MW'(w_widx % M);
  end

  // config registers: op, addr, axis, then edge words MSB byte first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k <= '0; r_word <= '0; r_op <= '0; r_addr <= '0; r_axis <= '0;
      for (int r = 0; r < EDGE_DEPTH; r++) r_edge[r] <= '0;
    end else if (!w_cfg_hit) begin
      r_k <= '0;
    end else if (w_cfg_take) begin
      r_k    <= r_k + 1'b1;
      r_word <= w_word_nxt;
      if (w_k < MAX_CHAINS)          r_op[w_ci]   <= configData;
      else if (w_k < 2 * MAX_CHAINS) r_addr[w_ci] <= configData[AW-1:0];
      else if (w_k < CFG_EDGE0)      r_axis[w_ci] <= configData;
      else if (w_last)               r_edge[w_erow][w_ecol] <= w_word_nxt;
    end
  end

  // accumulators: fold on accumulate beats, clear on eof or op rewrite
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else begin
      if (w_adv && r_s1_vld && w_is_acc)
        r_acc[r_s1_chain] <= r_s1_eof[0] ? '0 : w_accsum;
      if (w_cfg_take && w_k < MAX_CHAINS)
        r_acc[w_ci] <= '0;
    end
  end
endmodule

// File: tb/tb_filter_reduce_accum_unit.sv
// Directed bench: N=M=4, 32-bit lanes, 4-bit accumulators, 4 chains.
module tb_filter_reduce_accum_unit;
  localparam int ID = 33;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tracing = 1'b1;
  logic [7:0] configId = 8'(ID + 1);
  logic [7:0] configData = 8'h00;
  int         checks = 0;
  int         failures = 0;

  filter_reduce_accum_unit_if #(.N(4), .DATA_WIDTH(32), .MAX_CHAINS(4)) bus ();

  filter_reduce_accum_unit #(
    .N(4), .M(4), .DATA_WIDTH(32), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(ID),
    .EDGE_DEPTH(4), .COUNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tracing(tracing),
    .configId(configId), .configData(configData), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0][31:0] vec4(input logic [31:0] a0, a1, a2, a3);
    vec4 = {a3, a2, a1, a0};
  endfunction

  // chain0 op1/axis0/addr0, chain1 op1/axis2/addr4(=row0), chain2 op2/axis2, chain3 op7 (bypass)
  task automatic stream_cfg(input bit false_start);
    logic [7:0]  b[$];
    logic [31:0] w;
    logic [31:0] edges [4][4];
    edges = '{'{0, 10, 20, 30}, '{100, 200, 300, 400}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    b = {8'd1, 8'd1, 8'd2, 8'd7, 8'd0, 8'd4, 8'd0, 8'd1, 8'd0, 8'd2, 8'd2, 8'd0};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        w = edges[r][c];
        for (int bb = 3; bb >= 0; bb--) b.push_back(w[8*bb +: 8]);
      end
    tracing = 1'b0;
    if (false_start) begin
      for (int i = 0; i < 6; i++) begin @(negedge clk); configId = 8'(ID); configData = 8'hFF; end
      @(negedge clk); configId = 8'(ID + 1);
    end
    foreach (b[i]) begin @(negedge clk); configId = 8'(ID); configData = b[i]; end
    @(negedge clk); configId = 8'(ID + 1); tracing = 1'b1;
  endtask

  // drive one beat for one cycle; returns at the negedge after acceptance
  task automatic send_beat(input logic [1:0] ch, input logic [3:0][31:0] v, input logic [1:0] eof, input logic [1:0] bof);
    @(negedge clk);
    bus.valid_in = 1'b1; bus.chainId_in = ch; bus.vector_in = v; bus.eof_in = eof; bus.bof_in = bof;
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.vector_out !== '0) begin failures++; $display("FAIL reset_vector got=%h exp=0", bus.vector_out); end
    checks++; if (bus.chainId_out !== 2'd0) begin failures++; $display("FAIL reset_chain got=%0d exp=0", bus.chainId_out); end
    checks++; if (bus.eof_out !== 2'd0) begin failures++; $display("FAIL reset_eof got=%b exp=0", bus.eof_out); end
    checks++; if (bus.bof_out !== 2'd0) begin failures++; $display("FAIL reset_bof got=%b exp=0", bus.bof_out); end
    checks++; if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL reset_ready_in got=%b exp=1", bus.ready_in); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_filter_axis0;
    logic [3:0][31:0] exp;
    exp = vec4(1, 1, 1, 1);
    @(negedge clk);
    bus.valid_in = 1'b1; bus.chainId_in = 2'd0; bus.vector_in = vec4(5, 15, 25, 35);
    bus.eof_in = 2'b10; bus.bof_in = 2'b01;
    #1;
    checks++; if (bus.ready_in !== 1'b1) begin failures++; $display("FAIL axis0_ready_in got=%b exp=1", bus.ready_in); end
    @(negedge clk); bus.valid_in = 1'b0;
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL axis0_early_valid got=%b exp=0", bus.valid_out); end
    @(negedge clk);
    checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL axis0_valid got=%b exp=1", bus.valid_out); end
    checks++; if (bus.vector_out !== exp) begin failures++; $display("FAIL axis0_vec got=%h exp=%h", bus.vector_out, exp); end
    checks++; if (bus.chainId_out !== 2'd0) begin failures++; $display("FAIL axis0_chain got=%0d exp=0", bus.chainId_out); end
    checks++; if (bus.eof_out !== 2'b10) begin failures++; $display("FAIL axis0_eof got=%b exp=10", bus.eof_out); end
    checks++; if (bus.bof_out !== 2'b01) begin failures++; $display("FAIL axis0_bof got=%b exp=01", bus.bof_out); end
  endtask

  task automatic test_filter_boundary;
    logic [3:0][31:0] exp;
    exp = vec4(0, 1, 1, 0);
    send_beat(2'd0, vec4(0, 10, 40, 41), 2'b00, 2'b00);
    @(negedge clk);
    checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL bound_valid got=%b exp=1", bus.valid_out); end
    checks++; if (bus.vector_out !== exp) begin failures++; $display("FAIL bound_vec got=%h exp=%h", bus.vector_out, exp); end
  endtask

  task automatic test_filter_axis2;
    logic [3:0][31:0] exp;
    exp = vec4(2, 1, 0, 1);
    send_beat(2'd1, vec4(5, 5, 15, 40), 2'b00, 2'b00);
    @(negedge clk);
    checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL axis2_valid got=%b exp=1", bus.valid_out); end
    checks++; if (bus.vector_out !== exp) begin failures++; $display("FAIL axis2_vec got=%h exp=%h", bus.vector_out, exp); end
    checks++; if (bus.chainId_out !== 2'd1) begin failures++; $display("FAIL axis2_chain got=%0d exp=1", bus.chainId_out); end
  endtask

  task automatic test_bypass;
    logic [3:0][31:0] exp;
    exp = vec4(32'hDEADBEEF, 1, 2, 3);
    send_beat(2'd3, exp, 2'b01, 2'b00);
    @(negedge clk);
    checks++; if (bus.vector_out !== exp || bus.valid_out !== 1'b1) begin
      failures++; $display("FAIL bypass_vec got=%h valid=%b exp=%h", bus.vector_out, bus.valid_out, exp); end
  endtask

  // n beats of {5,5,5,5} on chain 2, eof only on the last one
  task automatic run_accum(input int nbeats, output int nout, output logic [3:0][31:0] got);
    nout = 0; got = '0;
    for (int cyc = 0; cyc < nbeats + 8; cyc++) begin
      @(negedge clk);
      if (cyc < nbeats) begin
        bus.valid_in = 1'b1; bus.chainId_in = 2'd2; bus.vector_in = vec4(5, 5, 5, 5);
        bus.eof_in = (cyc == nbeats - 1) ? 2'b01 : 2'b00; bus.bof_in = 2'b00;
      end else bus.valid_in = 1'b0;
      #1;
      if (bus.valid_out && bus.ready_out) begin nout++; got = bus.vector_out; end
    end
  endtask

  task automatic test_accumulate;
    int n; logic [3:0][31:0] got, exp;
    exp = vec4(12, 0, 0, 0);
    run_accum(3, n, got);
    checks++; if (n !== 1) begin failures++; $display("FAIL accum_count got=%0d exp=1", n); end
    checks++; if (got !== exp) begin failures++; $display("FAIL accum_vec got=%h exp=%h", got, exp); end
  endtask

  task automatic test_saturate;
    int n; logic [3:0][31:0] got, exp;
    exp = vec4(15, 0, 0, 0);
    run_accum(5, n, got);
    checks++; if (got !== exp || n !== 1) begin failures++; $display("FAIL sat_vec got=%h n=%0d exp=%h n=1", got, n, exp); end
  endtask

  task automatic test_op_write_clears;
    logic [3:0][31:0] exp;
    exp = vec4(4, 0, 0, 0);
    send_beat(2'd2, vec4(5, 5, 5, 5), 2'b00, 2'b00);
    stream_cfg(1'b0);
    send_beat(2'd2, vec4(5, 5, 5, 5), 2'b01, 2'b00);
    @(negedge clk);
    checks++; if (bus.vector_out !== exp || bus.valid_out !== 1'b1) begin
      failures++; $display("FAIL opclr_vec got=%h valid=%b exp=%h", bus.vector_out, bus.valid_out, exp); end
  endtask

  task automatic test_back_to_back;
    int sent, rcvd, order_err, extra;
    logic stall_ready;
    sent = 0; rcvd = 0; order_err = 0; extra = 0; stall_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      @(negedge clk);
      bus.ready_out = (cyc >= 5);
      if (sent < 6) begin
        bus.valid_in = 1'b1; bus.chainId_in = 2'd3; bus.vector_in = vec4(100 + sent, sent, 0, 0);
        bus.eof_in = 2'b00; bus.bof_in = 2'b00;
      end else bus.valid_in = 1'b0;
      #1;
      if (cyc >= 2 && cyc < 5) stall_ready = stall_ready | bus.ready_in;
      if (bus.valid_in && bus.ready_in) sent++;
      if (bus.valid_out && bus.ready_out) begin
        if (bus.vector_out[0] !== 32'(100 + rcvd)) order_err++;
        rcvd++;
      end
    end
    bus.valid_in = 1'b0; bus.ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (bus.valid_out) extra++; end
    checks++; if (stall_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready got=%b exp=0", stall_ready); end
    checks++; if (rcvd !== 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", rcvd); end
    checks++; if (order_err !== 0) begin failures++; $display("FAIL bp_order got=%0d errors exp=0", order_err); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL bp_dup got=%0d extra exp=0", extra); end
  endtask

  task automatic test_reset_mid;
    int quiet;
    logic [3:0][31:0] exp_byp, exp_acc;
    exp_byp = vec4(7, 0, 0, 0);
    exp_acc = vec4(4, 0, 0, 0);
    quiet = 0;
    send_beat(2'd2, vec4(5, 5, 5, 5), 2'b00, 2'b00);
    send_beat(2'd2, vec4(5, 5, 5, 5), 2'b00, 2'b00);
    // two bypass beats back to back: one at the output, one in stage 1
    @(negedge clk);
    bus.valid_in = 1'b1; bus.chainId_in = 2'd3; bus.vector_in = vec4(1, 0, 0, 0); bus.eof_in = 2'b00;
    @(negedge clk);
    bus.vector_in = vec4(2, 0, 0, 0);
    @(negedge clk);
    bus.valid_in = 1'b0;
    checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b exp=1", bus.valid_out); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.valid_out); end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.valid_out) quiet++; end
    checks++; if (quiet !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d outputs exp=0", quiet); end
    // config cleared: chain 2 now bypasses
    send_beat(2'd2, exp_byp, 2'b00, 2'b00);
    @(negedge clk);
    checks++; if (bus.vector_out !== exp_byp || bus.valid_out !== 1'b1) begin
      failures++; $display("FAIL rstmid_cfg got=%h valid=%b exp=%h", bus.vector_out, bus.valid_out, exp_byp); end
    stream_cfg(1'b0);
    send_beat(2'd2, vec4(5, 5, 5, 5), 2'b01, 2'b00);
    @(negedge clk);
    checks++; if (bus.vector_out !== exp_acc || bus.valid_out !== 1'b1) begin
      failures++; $display("FAIL rstmid_acc got=%h valid=%b exp=%h", bus.vector_out, bus.valid_out, exp_acc); end
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.vector_in = '0; bus.chainId_in = '0;
    bus.eof_in = '0; bus.bof_in = '0; bus.ready_out = 1'b1;
    test_reset();
    stream_cfg(1'b1);
    test_filter_axis0();
    test_filter_boundary();
    test_filter_axis2();
    test_bypass();
    test_accumulate();
    test_saturate();
    test_op_write_clears();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout exceeded 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
